// File: rtl/ssf_pkg.sv
// Shared types for the SSF mapper register-file write path: register window base,
// captured-write record and capture FSM states.
package ssf_pkg;

    localparam logic [23:0] SSF_REG_BASE = 24'hA130F0;

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] data;
        logic [1:0]  be;
    } ssf_wr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILT    = 2'd1,
        COMMIT  = 2'd2,
        RELEASE = 2'd3
    } cap_state_t;

endpackage

// File: rtl/ssf_wr_fifo.sv
// Small synchronous FIFO of captured register writes, clocked on the falling edge.
// Head entry is read straight out of the storage registers.
module ssf_wr_fifo
    import ssf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  ssf_wr_t push_data,
    input  logic    pop,
    output ssf_wr_t head,
    output logic    push_accept,
    output logic    full,
    output logic    empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    ssf_wr_t     mem [DEPTH];
    logic        pop_ok;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // A pop in the same cycle frees the slot, so a full FIFO still accepts a push.
    assign pop_ok      = pop & ~empty;
    assign push_accept = push & (~full | pop_ok);

    assign head = mem[rd_ptr[AW-1:0]];

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_accept) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ssf_wr_capture.sv
// Captures 68k writes to the /TIME register window, filters the strobe on clk50 and
// queues them for the register logic. Optional counters: SSF_WR_CAPTURE_STATS_EN.
module ssf_wr_capture
    import ssf_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR  = SSF_REG_BASE,
    parameter int unsigned FILT_LEN   = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk50,
    input  logic        rst,
    input  logic        as,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [23:1] addr,
    input  logic [15:0] data_in,
    output logic        wr_valid,
    input  logic        wr_ready,
    output logic [2:0]  wr_idx,
    output logic [15:0] wr_data,
    output logic [1:0]  wr_be,
    output logic        ovf,
    input  logic        ovf_clr,
`ifdef SSF_WR_CAPTURE_STATS_EN
    output logic [7:0]  drop_cnt,
    output logic [15:0] wr_cnt,
`endif
    output cap_state_t  dbg_state
);

    localparam logic [2:0] FILT_LEN_W = 3'(FILT_LEN);

    logic       hit;
    logic       hit_meta;
    logic       hit_s;
    cap_state_t state;
    cap_state_t state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;
    logic       commit;
    logic       pop_fire;
    logic       push_accept;
    logic       fifo_full;
    logic       fifo_empty;
    logic       drop;
    ssf_wr_t    cap_entry;
    ssf_wr_t    head;

    assign hit = ~as & (~we_lo | ~we_hi) & (addr[23:4] == BASE_ADDR[23:4]);

    always_ff @(negedge clk50 or negedge rst) begin
        if (!rst) begin
            hit_meta <= 1'b0;
            hit_s    <= 1'b0;
        end else begin
            hit_meta <= hit;
            hit_s    <= hit_meta;
        end
    end

    always_ff @(negedge clk50 or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts qualifying samples in FILT and consecutive idle samples in RELEASE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (hit_s) begin
                    cnt_nxt   = 3'd1;
                    state_nxt = (FILT_LEN == 1) ? COMMIT : FILT;
                end
            end
            FILT: begin
                if (!hit_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 3'd1;
                    if (cnt + 3'd1 == FILT_LEN_W) begin
                        state_nxt = COMMIT;
                    end
                end
            end
            COMMIT: begin
                state_nxt = RELEASE;
                cnt_nxt   = '0;
            end
            RELEASE: begin
                if (hit_s) begin
                    cnt_nxt = '0;
                end else if (cnt == 3'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        commit    = (state == COMMIT);
        dbg_state = state;
    end

    // Handshake: the head entry transfers on a falling edge where wr_valid & wr_ready;
    // while wr_valid is high and wr_ready low the head fields hold steady.
    assign pop_fire = wr_valid & wr_ready;

    assign cap_entry.idx  = addr[3:1];
    assign cap_entry.data = data_in;
    assign cap_entry.be   = {~we_hi, ~we_lo};

    ssf_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk50),
        .rst         (rst),
        .push        (commit),
        .push_data   (cap_entry),
        .pop         (pop_fire),
        .head        (head),
        .push_accept (push_accept),
        .full        (fifo_full),
        .empty       (fifo_empty)
    );

    assign drop     = commit & ~push_accept;
    assign wr_valid = ~fifo_empty;
    assign wr_idx   = head.idx;
    assign wr_data  = head.data;
    assign wr_be    = head.be;

    always_ff @(negedge clk50 or negedge rst) begin
        if (!rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

`ifdef SSF_WR_CAPTURE_STATS_EN
    always_ff @(negedge clk50 or negedge rst) begin
        if (!rst) begin
            drop_cnt <= '0;
            wr_cnt   <= '0;
        end else begin
            if (ovf_clr) begin
                drop_cnt <= drop ? 8'd1 : 8'd0;
            end else if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (commit && push_accept) begin
                wr_cnt <= wr_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/ssf_wr_capture.md
Name: ssf_wr_capture

Overview:
- Upstream front end for the SSF mapper's register file.
- Watches the asynchronous 68k bus for writes to the 16-byte /TIME register window and filters the write strobe on clk50.
- Latches the register index, data and byte lanes, then queues each write in a small FIFO.
- Presents queued writes to the bank/control register logic through a valid/ready handshake, so register updates never sample a bus that is still settling.

Parameters:
- BASE_ADDR, 24'hA130F0, byte address of the 16-byte register window; bits [3:0] are ignored.
- FILT_LEN, 3, consecutive synchronized clk50 samples of an active write needed to commit it (legal range 1..7).
- FIFO_DEPTH, 4, number of entries; must be a power of two, 2..16.

Ports:
- clk50  input  1  system clock; all logic runs on its negative edge.
- rst  input  1  asynchronous, active-low reset.
- as  input  1  68k address strobe, active low, asynchronous.
- we_lo  input  1  lower-byte write strobe, active low, asynchronous.
- we_hi  input  1  upper-byte write strobe, active low, asynchronous.
- addr  input  23  CPU address [23:1].
- data_in  input  16  CPU data bus, read-only view.
- wr_valid  output  1  head FIFO entry is available.
- wr_ready  input  1  consumer accepts the head entry this cycle.
- wr_idx  output  3  register index, taken from addr[3:1].
- wr_data  output  16  captured data.
- wr_be  output  2  byte enables {hi, lo}, active high.
- ovf  output  1  sticky flag: a write was dropped because the FIFO was full.
- ovf_clr  input  1  clears ovf.

Behaviour:
- Clock and reset: one clock, clk50, with all flops on its negative edge. Reset is asynchronous and active-low (rst).
- Reset values: wr_valid=0, wr_idx=0, wr_data=0, wr_be=0, ovf=0. FIFO is empty, FSM is in IDLE, filter counter is 0.
- Decode (combinational): hit = !as & (!we_lo | !we_hi) & {addr[23:4],4'd0}==BASE_ADDR. hit passes through a 2-flop synchronizer to give hit_s.
- IDLE: when hit_s=1, load cnt=1 and go to FILT. If FILT_LEN==1, commit immediately instead.
- FILT: while hit_s=1, increment cnt. When cnt reaches FILT_LEN, go to COMMIT. If hit_s drops first, go back to IDLE; this is a glitch and nothing is captured.
- COMMIT (one cycle): sample addr[3:1], data_in and the inverted strobes. Push them if the FIFO is not full; otherwise set ovf. Then go to RELEASE.
- RELEASE: wait for hit_s=0 on 2 consecutive samples, then return to IDLE. This guarantees exactly one commit per bus cycle, however long the strobe is held.
- Write-to-visible latency: hit assertion to wr_valid is 2 sync + FILT_LEN + 1 clocks, i.e. 6 clocks at the defaults.
- Handshake: the head entry is popped when wr_valid & wr_ready. wr_idx, wr_data and wr_be are the head entry and stay stable while wr_valid=1 and wr_ready=0. Outputs come straight from registered FIFO storage.
- FIFO full/empty:
  - Full plus commit: the entry is dropped, ovf is set, and the FIFO is unchanged.
  - A pop and a push in the same cycle are both honoured, even when the FIFO is full; the pop frees the slot first.
  - wr_valid=0 exactly when the FIFO is empty.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty, and pointers wrap naturally.
- ovf: set has priority over ovf_clr in the same cycle.
- Reset mid-operation: any in-flight capture is abandoned, the FIFO is flushed, and the next bus write is captured normally.

Optional Feature:
- SSF_WR_CAPTURE_STATS_EN defined:
  - Adds output drop_cnt [7:0], a count of dropped writes that saturates at 8'hFF. It resets to 0 and is cleared by ovf_clr.
  - Adds output wr_cnt [15:0], a count of accepted pushes that wraps and resets to 0.
- Not defined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package ssf_pkg holds:
  - constant SSF_REG_BASE = 24'hA130F0;
  - typedef ssf_wr_t {logic [2:0] idx; logic [15:0] data; logic [1:0] be;};
  - enum cap_state_t {IDLE, FILT, COMMIT, RELEASE}.
- One sub-module, ssf_wr_fifo: a parameterised synchronous FIFO of ssf_wr_t with push/pop/full/empty. The capture FSM stays in the top of the block.

Test Plan:
- Byte-pair write 16'h8005 to 24'hA130F0, strobe held 10 clocks -> exactly one entry {idx=0, data=16'h8005, be=2'b11}; wr_valid rises 6 clocks after the strobe.
- we_lo pulse of only 2 clk50 cycles at 24'hA130F2 -> no entry, wr_valid stays 0.
- Five writes to idx 1..5 with wr_ready=0 -> first four queued in order, fifth dropped and ovf=1. Then wr_ready=1 drains 1,2,3,4 over 4 consecutive clocks.
- Write to 24'hA13100 (outside the window) held 10 clocks -> no entry.
- Simultaneous pop and push while full -> occupancy stays 4, order is preserved, ovf stays 0.
- rst asserted during FILT and with 2 entries queued -> wr_valid=0 immediately; the next write to idx 7 data 16'h001F emerges as the only entry.
